// File: rtl/bp_pool_pkg.sv
// Shared types and helpers for the 2x2 average-unpooling backprop sequencer.
package bp_pool_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    STREAM,
    FIN
  } state_e;

  typedef struct packed {
    logic [31:0] row_off;
    logic [31:0] col_off;
  } quad_origin_t;

  // Quadrant origin inside the output plane: bit 1 picks the lower half, bit 0 the right half.
  function automatic quad_origin_t quad_origin(input logic [1:0] sub, input logic [31:0] tile_edge);
    quad_origin_t o;
    o.row_off = sub[1] ? tile_edge : 32'd0;
    o.col_off = sub[0] ? tile_edge : 32'd0;
    return o;
  endfunction

endpackage

// File: rtl/backprop_pool_seq.sv
// Sequencer for the 2x2 average-unpooling backprop datapath: walks the four
// quadrants, captures each gradient tile and streams it row by row to the
// DDR3 write path. Optional stall counter: BACKPROP_POOL_SEQ_STALL_CNT_EN.
module backprop_pool_seq
  import bp_pool_pkg::*;
#(
  parameter int WIDTH_IN   = 4,
  parameter int WIDTH_OUT  = 2 * WIDTH_IN,
  parameter int ADDR_W     = 27,
  parameter int LINE_WORDS = 2 * WIDTH_OUT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          sub_block,
  input  logic [WIDTH_OUT*WIDTH_OUT*WORD_W-1:0] pool_out,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [ADDR_W-1:0]                   wr_addr,
  output logic [WIDTH_OUT*WORD_W-1:0]         wr_data,
  output logic                                wr_last
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]                         stall_cycles
`endif
);

  localparam int ROW_W    = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;
  localparam int ROW_BITS = WIDTH_OUT * WORD_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WIDTH_OUT - 1);

  typedef logic [ROW_BITS-1:0] row_t;

  state_e            state_q, state_d;
  logic [1:0]        sub_q, sub_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  row_t              data_q, data_d;
  row_t              tile_q [WIDTH_OUT];
  logic              tile_load;
  logic              handshake;

  // Word address of a beat: quadrant origin plus row stride, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [1:0] sub,
                                                   input logic [ROW_W-1:0] row);
    quad_origin_t o;
    logic [31:0]  off;
    o   = quad_origin(sub, 32'(WIDTH_OUT));
    off = (o.row_off + 32'(row)) * 32'(LINE_WORDS) + o.col_off;
    return base + off[ADDR_W-1:0];
  endfunction

  assign wr_valid  = (state_q == STREAM);
  assign wr_last   = wr_valid && (sub_q == 2'd3) && (row_q == LAST_ROW);
  assign handshake = wr_valid && wr_ready;

  assign busy      = busy_q;
  assign done      = done_q;
  assign sub_block = sub_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;

  // Next-state logic: quadrant/row walk, beat address and data preparation.
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    row_d     = row_q;
    base_d    = base_q;
    busy_d    = busy_q;
    done_d    = done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tile_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          sub_d   = 2'd0;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        tile_load = 1'b1;
        data_d    = pool_out[0 +: ROW_BITS];
        addr_d    = beat_addr(base_q, sub_q, '0);
        state_d   = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          if (row_q != LAST_ROW) begin
            row_d  = row_q + 1'b1;
            data_d = tile_q[row_d];
            addr_d = beat_addr(base_q, sub_q, row_d);
          end else if (sub_q != 2'd3) begin
            row_d   = '0;
            sub_d   = sub_q + 2'd1;
            state_d = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        sub_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sub_q   <= 2'd0;
      row_q   <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      row_q   <= row_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Tile buffer: snapshot of the datapath result for the current quadrant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIDTH_OUT; r++) begin
        tile_q[r] <= '0;
      end
    end else if (tile_load) begin
      for (int r = 0; r < WIDTH_OUT; r++) begin
        tile_q[r] <= pool_out[r*ROW_BITS +: ROW_BITS];
      end
    end
  end

`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter next value: clear on a new pass, saturate while backpressured.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = 32'd0;
    end else if (wr_valid && !wr_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_backprop_pool_seq.sv
// Self-checking bench for backprop_pool_seq: a behavioural datapath stand-in
// drives pool_out, and every pass is compared beat by beat with a plane-level
// model. Build with BACKPROP_POOL_SEQ_STALL_CNT_EN to also check stall_cycles.
module tb_backprop_pool_seq;

  localparam int WIDTH_IN   = 4;
  localparam int WIDTH_OUT  = 8;
  localparam int ADDR_W     = 27;
  localparam int LINE_WORDS = 16;
  localparam int BEATS      = 32;
  localparam int PASS_CYC   = 4 * (1 + WIDTH_OUT) + 2;
  localparam int MAXC       = 2000;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            start = 1'b0;
  logic [ADDR_W-1:0]               base_addr = '0;
  logic                            busy, done;
  logic [1:0]                      sub_block;
  logic [WIDTH_OUT*WIDTH_OUT*32-1:0] pool_out;
  logic                            wr_valid;
  logic                            wr_ready = 1'b1;
  logic [ADDR_W-1:0]               wr_addr;
  logic [WIDTH_OUT*32-1:0]         wr_data;
  logic                            wr_last;
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
  logic [31:0]                     stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] inPlane [64];
  bit          fineMode = 1'b0;
  logic [31:0] hashSeed = 32'h0;
  int          planeRev = 0;

  logic [ADDR_W-1:0]       expAddr[$];
  logic [WIDTH_OUT*32-1:0] expData[$];
  logic                    expLast[$];
  logic [ADDR_W-1:0]       obsAddr[$];
  logic [WIDTH_OUT*32-1:0] obsData[$];
  logic                    obsLast[$];

  backprop_pool_seq #(
    .WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .sub_block(sub_block), .pool_out(pool_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last)
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Datapath stand-in: either true 2x2 average unpooling of an 8x8 input
  // gradient plane (quadrant picked by sub) or a per-element hash.
  function automatic logic [31:0] dpOut(input logic [1:0] sub, input int k);
    int r, c;
    r = k / WIDTH_OUT;
    c = k % WIDTH_OUT;
    if (fineMode)
      return hashSeed + 32'(sub) * 32'h0100_0193 + 32'(k) * 32'h9E37_79B1;
    return inPlane[(int'(sub[1]) * WIDTH_IN + r / 2) * (2 * WIDTH_IN)
                   + int'(sub[0]) * WIDTH_IN + c / 2] >> 2;
  endfunction

  always @(sub_block, planeRev) begin
    for (int k = 0; k < WIDTH_OUT * WIDTH_OUT; k++)
      pool_out[k*32 +: 32] = dpOut(sub_block, k);
  end

  task automatic setPlaneRamp();
    fineMode = 1'b0;
    for (int i = 0; i < 64; i++) inPlane[i] = 32'h1000 + 32'(i) * 32'd4;
    planeRev++;
  endtask

  task automatic setPlaneHash();
    fineMode = 1'b1;
    hashSeed = $urandom;
    planeRev++;
  endtask

  // Expected beat list for one pass: quadrants in order, rows top to bottom.
  task automatic buildExpected(input logic [ADDR_W-1:0] base);
    logic [63:0]             a;
    logic [WIDTH_OUT*32-1:0] d;
    expAddr.delete(); expData.delete(); expLast.delete();
    for (int sub = 0; sub < 4; sub++) begin
      for (int row = 0; row < WIDTH_OUT; row++) begin
        a = 64'(base) + 64'(((sub / 2) * WIDTH_OUT + row) * LINE_WORDS + (sub % 2) * WIDTH_OUT);
        for (int c = 0; c < WIDTH_OUT; c++) d[c*32 +: 32] = dpOut(2'(sub), row * WIDTH_OUT + c);
        expAddr.push_back(a[ADDR_W-1:0]);
        expData.push_back(d);
        expLast.push_back(sub == 3 && row == WIDTH_OUT - 1);
      end
    end
  endtask

  // Drives one pass from a negedge with the DUT idle and records what it
  // writes. Cycle 1 is the cycle in which start is presented.
  task automatic collectPass(input logic [ADDR_W-1:0] base, input bit holdStart,
                             input int stallBeat, input int stallLen, input bit randReady,
                             input int extraCycle, input logic [ADDR_W-1:0] extraBase,
                             output int doneCycle, output int busyCycles, output int firstBusy,
                             output int firstValid, output int unstable, output int stallsSeen,
                             output logic postBusy, output logic postDone);
    int                      cycle, stallLeft;
    bit                      prevStall;
    logic [ADDR_W-1:0]       pAddr;
    logic [WIDTH_OUT*32-1:0] pData;
    logic                    pLast;
    obsAddr.delete(); obsData.delete(); obsLast.delete();
    doneCycle = -1; busyCycles = 0; firstBusy = -1; firstValid = -1;
    unstable = 0; stallsSeen = 0; stallLeft = stallLen; prevStall = 1'b0;
    pAddr = '0; pData = '0; pLast = 1'b0;
    start = 1'b1; base_addr = base; wr_ready = 1'b1; cycle = 1;
    while (doneCycle < 0 && cycle < MAXC) begin
      @(negedge clk);
      cycle++;
      start = holdStart;
      base_addr = ADDR_W'($urandom);
      if (cycle == extraCycle) begin
        start = 1'b1;
        base_addr = extraBase;
      end
      if (busy) begin
        busyCycles++;
        if (firstBusy < 0) firstBusy = cycle;
      end
      if (prevStall && (!wr_valid || wr_addr !== pAddr || wr_data !== pData || wr_last !== pLast))
        unstable++;
      if (wr_valid) begin
        if (firstValid < 0) firstValid = cycle;
        if (stallBeat == obsAddr.size() && stallLeft > 0) begin
          wr_ready = 1'b0;
          stallLeft--;
        end else if (randReady) wr_ready = ($urandom_range(0, 3) != 0);
        else wr_ready = 1'b1;
        if (wr_ready) begin
          obsAddr.push_back(wr_addr);
          obsData.push_back(wr_data);
          obsLast.push_back(wr_last);
        end else stallsSeen++;
        prevStall = !wr_ready;
        pAddr = wr_addr; pData = wr_data; pLast = wr_last;
      end else begin
        wr_ready = randReady ? ($urandom_range(0, 1) != 0) : 1'b1;
        prevStall = 1'b0;
      end
      if (done) doneCycle = cycle;
    end
    @(negedge clk);
    postBusy = busy;
    postDone = done;
    wr_ready = 1'b1;
    if (!holdStart) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", wr_valid); end
    checks++; if (wr_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", wr_last); end
    checks++; if (sub_block !== 2'd0) begin errors++; $display("[TB] FAIL reset_sub: got %0d expected 0", sub_block); end
    checks++; if (wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0h expected 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", wr_data); end
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cycles); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic_pass();
    int doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    setPlaneRamp();
    buildExpected(27'h100);
    collectPass(27'h100, 1'b0, -1, 0, 1'b0, -1, '0, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
    checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL basic_beats: got %0d expected %0d", obsAddr.size(), BEATS); end
    for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
      checks++;
      if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) begin
        errors++;
        $display("[TB] FAIL basic_beat%0d: got addr=%0h last=%b data=%0h expected addr=%0h last=%b data=%0h",
                 i, obsAddr[i], obsLast[i], obsData[i], expAddr[i], expLast[i], expData[i]);
      end
    end
    if (obsAddr.size() > 9) begin
      checks++; if (obsAddr[1] !== 27'h110) begin errors++; $display("[TB] FAIL basic_addr_s0r1: got %0h expected 110", obsAddr[1]); end
      checks++; if (obsAddr[9] !== 27'h118) begin errors++; $display("[TB] FAIL basic_addr_s1r1: got %0h expected 118", obsAddr[9]); end
    end
    checks++; if (doneC != PASS_CYC) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", doneC, PASS_CYC); end
    checks++; if (firstV != 3) begin errors++; $display("[TB] FAIL basic_first_valid: got %0d expected 3", firstV); end
    checks++; if (firstB != 2) begin errors++; $display("[TB] FAIL basic_first_busy: got %0d expected 2", firstB); end
    checks++; if (busyC != PASS_CYC - 1) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", busyC, PASS_CYC - 1); end
    checks++; if (pb !== 1'b0 || pd !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_done: got busy=%b done=%b expected 0 0", pb, pd); end
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL basic_stall: got %0d expected 0", stall_cycles); end
`endif
  endtask

  task automatic test_backpressure();
    int doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    logic [ADDR_W-1:0] base;
    setPlaneHash();
    base = ADDR_W'($urandom);
    buildExpected(base);
    collectPass(base, 1'b0, 2 * WIDTH_OUT + 3, 5, 1'b0, -1, '0, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
    checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected %0d", obsAddr.size(), BEATS); end
    for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
      checks++;
      if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: got addr=%0h last=%b data=%0h expected addr=%0h last=%b data=%0h",
                 i, obsAddr[i], obsLast[i], obsData[i], expAddr[i], expLast[i], expData[i]);
      end
    end
    checks++; if (unst != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", unst); end
    checks++; if (stalls != 5) begin errors++; $display("[TB] FAIL bp_stall_seen: got %0d expected 5", stalls); end
    checks++; if (doneC != PASS_CYC + 5) begin errors++; $display("[TB] FAIL bp_done_cycle: got %0d expected %0d", doneC, PASS_CYC + 5); end
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("[TB] FAIL bp_stall_cnt: got %0d expected 5", stall_cycles); end
`endif
  endtask

  task automatic test_start_while_busy();
    int doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    setPlaneHash();
    buildExpected(27'h100);
    collectPass(27'h100, 1'b0, -1, 0, 1'b0, 10, 27'h900, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
    checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL swb_beats: got %0d expected %0d", obsAddr.size(), BEATS); end
    for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
      checks++;
      if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) begin
        errors++;
        $display("[TB] FAIL swb_beat%0d: got addr=%0h last=%b expected addr=%0h last=%b",
                 i, obsAddr[i], obsLast[i], expAddr[i], expLast[i]);
      end
    end
    checks++; if (doneC != PASS_CYC) begin errors++; $display("[TB] FAIL swb_done_cycle: got %0d expected %0d", doneC, PASS_CYC); end
    checks++; if (pb !== 1'b0) begin errors++; $display("[TB] FAIL swb_no_requeue: busy got %b expected 0", pb); end
  endtask

  task automatic test_reset_mid_stream();
    int beats, cyc, doneSeen, doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    logic [ADDR_W-1:0] base;
    setPlaneHash();
    beats = 0; cyc = 0; doneSeen = 0;
    start = 1'b1; base_addr = 27'h200; wr_ready = 1'b1;
    while (!(wr_valid && beats == WIDTH_OUT + 4) && cyc < MAXC) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (wr_valid && beats != WIDTH_OUT + 4) beats++;
    end
    checks++; if (cyc >= MAXC) begin errors++; $display("[TB] FAIL rst_reach_s1r4: got timeout after %0d cycles expected beat 12", cyc); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_flags: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (wr_valid !== 1'b0 || wr_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got valid=%b last=%b expected 0 0", wr_valid, wr_last); end
    checks++; if (wr_addr !== '0 || wr_data !== '0 || sub_block !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_regs: got addr=%0h sub=%0d data=%0h expected 0", wr_addr, sub_block, wr_data); end
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_stall: got %0d expected 0", stall_cycles); end
`endif
    repeat (2) begin @(negedge clk); if (done) doneSeen++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) doneSeen++; end
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL rst_no_done: got %0d active cycles expected 0", doneSeen); end
    base = ADDR_W'($urandom);
    buildExpected(base);
    collectPass(base, 1'b0, -1, 0, 1'b0, -1, '0, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
    checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL rst_clean_beats: got %0d expected %0d", obsAddr.size(), BEATS); end
    for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
      checks++;
      if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) begin
        errors++;
        $display("[TB] FAIL rst_clean_beat%0d: got addr=%0h last=%b expected addr=%0h last=%b",
                 i, obsAddr[i], obsLast[i], expAddr[i], expLast[i]);
      end
    end
    checks++; if (doneC != PASS_CYC) begin errors++; $display("[TB] FAIL rst_clean_done: got %0d expected %0d", doneC, PASS_CYC); end
  endtask

  task automatic test_address_wrap();
    int doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    logic [ADDR_W-1:0] base;
    base = 27'h7FF_FFFC;
    setPlaneHash();
    buildExpected(base);
    collectPass(base, 1'b0, -1, 0, 1'b0, -1, '0, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
    checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL wrap_beats: got %0d expected %0d", obsAddr.size(), BEATS); end
    if (obsAddr.size() > WIDTH_OUT) begin
      checks++; if (obsAddr[WIDTH_OUT] !== 27'd4) begin errors++; $display("[TB] FAIL wrap_s1r0: got %0h expected 4", obsAddr[WIDTH_OUT]); end
    end
    for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
      checks++;
      if (obsAddr[i] !== expAddr[i] || obsLast[i] !== expLast[i]) begin
        errors++;
        $display("[TB] FAIL wrap_beat%0d: got addr=%0h last=%b expected addr=%0h last=%b",
                 i, obsAddr[i], obsLast[i], expAddr[i], expLast[i]);
      end
    end
  endtask

  task automatic test_random_passes();
    int doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    logic [ADDR_W-1:0] base;
    for (int p = 0; p < 3; p++) begin
      setPlaneHash();
      base = ADDR_W'($urandom);
      buildExpected(base);
      collectPass(base, 1'b0, -1, 0, 1'b1, -1, '0, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
      checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL rand%0d_beats: got %0d expected %0d", p, obsAddr.size(), BEATS); end
      for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
        checks++;
        if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) begin
          errors++;
          $display("[TB] FAIL rand%0d_beat%0d: got addr=%0h last=%b data=%0h expected addr=%0h last=%b data=%0h",
                   p, i, obsAddr[i], obsLast[i], obsData[i], expAddr[i], expLast[i], expData[i]);
        end
      end
      checks++; if (unst != 0) begin errors++; $display("[TB] FAIL rand%0d_stable: got %0d changes expected 0", p, unst); end
      checks++; if (doneC != PASS_CYC + stalls) begin errors++; $display("[TB] FAIL rand%0d_done: got %0d expected %0d", p, doneC, PASS_CYC + stalls); end
`ifdef BACKPROP_POOL_SEQ_STALL_CNT_EN
      checks++; if (stall_cycles !== 32'(stalls)) begin errors++; $display("[TB] FAIL rand%0d_stall_cnt: got %0d expected %0d", p, stall_cycles, stalls); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int doneC, busyC, firstB, firstV, unst, stalls; logic pb, pd;
    logic [ADDR_W-1:0] base;
    for (int p = 0; p < 2; p++) begin
      setPlaneHash();
      base = ADDR_W'($urandom);
      buildExpected(base);
      collectPass(base, (p == 0), -1, 0, 1'b0, -1, '0, doneC, busyC, firstB, firstV, unst, stalls, pb, pd);
      checks++; if (obsAddr.size() != BEATS) begin errors++; $display("[TB] FAIL b2b%0d_beats: got %0d expected %0d", p, obsAddr.size(), BEATS); end
      for (int i = 0; i < obsAddr.size() && i < BEATS; i++) begin
        checks++;
        if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) begin
          errors++;
          $display("[TB] FAIL b2b%0d_beat%0d: got addr=%0h last=%b expected addr=%0h last=%b",
                   p, i, obsAddr[i], obsLast[i], expAddr[i], expLast[i]);
        end
      end
      checks++; if (doneC != PASS_CYC) begin errors++; $display("[TB] FAIL b2b%0d_done: got %0d expected %0d", p, doneC, PASS_CYC); end
      checks++; if (firstB != 2) begin errors++; $display("[TB] FAIL b2b%0d_first_busy: got %0d expected 2", p, firstB); end
      checks++; if (pb !== 1'b0) begin errors++; $display("[TB] FAIL b2b%0d_gap: busy got %b expected 0", p, pb); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_pass();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_stream();
    test_address_wrap();
    test_random_passes();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
